// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle WIDTH-bit subtractor computing diff = a - b - bin, DIGIT bits
//   per clock. The borrow is carried between cycles in a register, so a wide
//   subtract costs a DIGIT-bit subtractor plus shift registers. The cost is
//   N = WIDTH/DIGIT cycles of latency.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per cycle (1..WIDTH, must divide WIDTH exactly)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset, highest priority
//   start  in   1      request; accepted only when busy=0
//   a      in   WIDTH  minuend, sampled on the accepting edge
//   b      in   WIDTH  subtrahend, sampled on the accepting edge
//   bin    in   1      borrow-in, sampled on the accepting edge
//   busy   out  1      high while a subtraction is in progress
//   done   out  1      one-cycle pulse: diff/bout/zero just updated
//   diff   out  WIDTH  a - b - bin modulo 2^WIDTH
//   bout   out  1      final borrow-out (a < b + bin, unsigned)
//   zero   out  1      diff == 0 for the latest result
//
// Handshake: start is sampled on every rising edge. It is accepted when the
//   FSM is in IDLE or DONE, which means busy=0. On the accepting edge, a, b and
//   bin are captured, and busy rises. Exactly N edges later, done pulses high
//   for one cycle and busy falls on that same edge. start is ignored while
//   busy=1, and a/b/bin are don't-care while busy=1. diff/bout/zero change only
//   on a done edge or on reset. The FSM state is held in the enum signal
//   'state' so that checkers can bind to it.

module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   chunk;     // {borrow, digit} of the current chunk
    logic [WIDTH-1:0] res_next;  // result register after this chunk lands
    logic             last;

    always_comb begin
        chunk    = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]}
                   - (DIGIT+1)'(brw);
        // Chunks enter at the MSB end; after N shifts chunk 0 sits at the LSBs.
        res_next = (res_sr >> DIGIT)
                   | (WIDTH'(chunk[DIGIT-1:0]) << (WIDTH - DIGIT));
        last     = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new start exactly like IDLE (back-to-back).
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    brw    <= chunk[DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff  <= res_next;
                        bout  <= chunk[DIGIT];
                        zero  <= (res_next == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
